// File: rtl/neuro_spider_pkg.sv
// Shared definitions for the TheNeuroSpider job sequencer: engine config
// register map, cache-select codes, descriptor layout and sequencer states.
package neuro_spider_pkg;

  localparam int DESC_W       = 96;
  localparam int FIELD_W      = 16;
  localparam int NUM_CFG_REGS = 6;

  // Engine configuration registers, written in this order for every job
  localparam logic [15:0] REG_IN_OFF  = 16'h8000;
  localparam logic [15:0] REG_IDX_OFF = 16'h8001;
  localparam logic [15:0] REG_WGT_OFF = 16'h8002;
  localparam logic [15:0] REG_NUM_OPS = 16'h8003;
  localparam logic [15:0] REG_DEST    = 16'h8004;
  localparam logic [15:0] REG_ACT_SEL = 16'h8005;

  // Cache-select code used while programming the config registers
  localparam logic [1:0] CACHE_SEL_CFG = 2'b00;

  // Descriptor field positions (LSB of each 16-bit field)
  localparam int IN_OFF_LSB  = 0;
  localparam int IDX_OFF_LSB = 16;
  localparam int WGT_OFF_LSB = 32;
  localparam int NUM_OPS_LSB = 48;
  localparam int DEST_LSB    = 64;
  localparam int ACT_SEL_LSB = 80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_GUARD,
    ST_WAIT
  } seq_state_e;

  // Descriptor field that belongs in config register 0x8000+idx
  function automatic logic [FIELD_W-1:0] descField(input logic [DESC_W-1:0] desc,
                                                   input logic [2:0] idx);
    case (idx)
      3'd0:    return desc[IN_OFF_LSB  +: FIELD_W];
      3'd1:    return desc[IDX_OFF_LSB +: FIELD_W];
      3'd2:    return desc[WGT_OFF_LSB +: FIELD_W];
      3'd3:    return desc[NUM_OPS_LSB +: FIELD_W];
      3'd4:    return desc[DEST_LSB    +: FIELD_W];
      3'd5:    return desc[ACT_SEL_LSB +: FIELD_W];
      default: return '0;
    endcase
  endfunction

  // Engine address of config register idx
  function automatic logic [15:0] cfgAddr(input logic [2:0] idx);
    return REG_IN_OFF + {13'b0, idx};
  endfunction

endpackage

// File: rtl/neuro_job_fifo.sv
// Descriptor queue between the host and the sequencer FSM. Flush empties it
// on the next edge and overrides any push or pop in the same cycle; a pop only
// ever returns an entry that was already stored (no write-through bypass).
module neuro_job_fifo
  import neuro_spider_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [DESC_W-1:0]       data_i,
  output logic [DESC_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Descriptor storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/neuro_job_sequencer.sv
// Job scheduler in front of the TheNeuroSpider engine: pops queued descriptors,
// programs the six config registers, pulses StartOperation and waits for
// ReadyForNextOp. The host owns the engine bus only while the sequencer is idle.
module neuro_job_sequencer
  import neuro_spider_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    job_valid,
  input  logic [DESC_W-1:0]       job_desc,
  output logic                    job_ready,
  input  logic                    flush,
  input  logic [15:0]             host_address,
  input  logic [15:0]             host_wdata,
  input  logic                    host_we,
  input  logic [1:0]              host_cache_sel,
  input  logic                    host_start,
  output logic                    host_stall,
  output logic [15:0]             eng_address,
  output logic [15:0]             eng_wdata,
  output logic                    eng_we,
  output logic [1:0]              eng_cache_sel,
  output logic                    eng_start,
  input  logic                    eng_ready,
  output logic                    busy,
  output logic                    job_done,
  output logic [15:0]             done_count,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic [15:0]       seqAddr_q, seqAddr_d;
  logic [15:0]       seqWdata_q, seqWdata_d;
  logic              seqWe_q, seqWe_d;
  logic [1:0]        seqSel_q, seqSel_d;
  logic              seqStart_q, seqStart_d;
  logic              jobDone_q, jobDone_d;
  logic [15:0]       doneCount_q, doneCount_d;
  logic              errTimeout_q, errTimeout_d;

  logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [DESC_W-1:0] fifoHead;
  logic [2:0]        nextCnt;
  logic              isIdle;

  assign fifoPush = job_valid && job_ready;
  assign nextCnt  = cnt_q + 3'd1;
  assign isIdle   = (state_q == ST_IDLE);

  neuro_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (flush),
    .data_i  (job_desc),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (pending)
  );

  // Next-state logic; sequencer bus outputs are computed one cycle ahead so they come straight from flops
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    desc_d       = desc_q;
    seqAddr_d    = seqAddr_q;
    seqWdata_d   = seqWdata_q;
    seqSel_d     = seqSel_q;
    seqWe_d      = 1'b0;
    seqStart_d   = 1'b0;
    jobDone_d    = 1'b0;
    doneCount_d  = doneCount_q;
    errTimeout_d = errTimeout_q;
    fifoPop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty && eng_ready && !flush) begin
          fifoPop = 1'b1;
          desc_d  = fifoHead;
          if (descField(fifoHead, 3'd3) == '0) begin
            jobDone_d   = 1'b1;
            doneCount_d = doneCount_q + 16'd1;
          end else begin
            state_d    = ST_CFG;
            cnt_d      = 3'd0;
            seqAddr_d  = cfgAddr(3'd0);
            seqWdata_d = descField(fifoHead, 3'd0);
            seqSel_d   = CACHE_SEL_CFG;
            seqWe_d    = 1'b1;
          end
        end
      end
      ST_CFG: begin
        if (cnt_q == 3'(NUM_CFG_REGS - 1)) begin
          state_d    = ST_START;
          seqStart_d = 1'b1;
        end else begin
          cnt_d      = nextCnt;
          seqAddr_d  = cfgAddr(nextCnt);
          seqWdata_d = descField(desc_q, nextCnt);
          seqSel_d   = CACHE_SEL_CFG;
          seqWe_d    = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        if (eng_ready) begin
          state_d     = ST_IDLE;
          jobDone_d   = 1'b1;
          doneCount_d = doneCount_q + 16'd1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d      = ST_IDLE;
          errTimeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) errTimeout_d = 1'b0;
  end

  // State, descriptor, bus and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      desc_q       <= '0;
      seqAddr_q    <= '0;
      seqWdata_q   <= '0;
      seqWe_q      <= 1'b0;
      seqSel_q     <= '0;
      seqStart_q   <= 1'b0;
      jobDone_q    <= 1'b0;
      doneCount_q  <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      desc_q       <= desc_d;
      seqAddr_q    <= seqAddr_d;
      seqWdata_q   <= seqWdata_d;
      seqWe_q      <= seqWe_d;
      seqSel_q     <= seqSel_d;
      seqStart_q   <= seqStart_d;
      jobDone_q    <= jobDone_d;
      doneCount_q  <= doneCount_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign job_ready   = !fifoFull;
  assign busy        = !isIdle;
  assign host_stall  = !isIdle;
  assign job_done    = jobDone_q;
  assign done_count  = doneCount_q;
  assign err_timeout = errTimeout_q;

  assign eng_address   = isIdle ? host_address   : seqAddr_q;
  assign eng_wdata     = isIdle ? host_wdata     : seqWdata_q;
  assign eng_we        = isIdle ? host_we        : seqWe_q;
  assign eng_cache_sel = isIdle ? host_cache_sel : seqSel_q;
  assign eng_start     = isIdle ? host_start     : seqStart_q;

endmodule
